// File: rtl/sb_dmem.sv
// Data-memory responder for the core's load/store port: byte-lane RAM with
// configurable wait states, aligned/extended load data and one-cycle ack/err.
module sb_dmem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        un_sign_i,
  input  logic [3:0]  byte_mask_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        ack_reg, err_reg;

  // Transaction captured at accept
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  mask_reg;
  logic        unsign_reg, is_read_reg, conflict_reg;

  // Extraction controls of the last successful read
  logic        rd_valid_reg, rd_unsign_reg;
  logic [1:0]  rd_off_reg;
  logic [3:0]  rd_mask_reg;

  logic        accept, enter_resp;
  logic [31:0] cur_addr, cur_wdata, offset, wdata_rep;
  logic [3:0]  cur_mask, lanes;
  logic        cur_unsign, cur_read, cur_conflict;
  logic        mask_ok, misaligned, out_of_range, txn_err;
  logic        wr_en, rd_en;
  logic [IDX_W-1:0] word_idx;
  logic [31:0] ram_q, shifted, ext;

  assign accept = (state_reg == S_IDLE) && (mem_re_i || mem_we_i);

  // With zero wait states the RAM access happens on the accept edge itself,
  // so decode straight from the inputs while idle.
  always_comb begin
    if (state_reg == S_IDLE) begin
      cur_addr     = addr_i;
      cur_wdata    = wdata_i;
      cur_mask     = byte_mask_i;
      cur_unsign   = un_sign_i;
      cur_read     = mem_re_i;
      cur_conflict = mem_re_i && mem_we_i;
    end else begin
      cur_addr     = addr_reg;
      cur_wdata    = wdata_reg;
      cur_mask     = mask_reg;
      cur_unsign   = unsign_reg;
      cur_read     = is_read_reg;
      cur_conflict = conflict_reg;
    end
  end

  always_comb begin
    offset       = cur_addr - BASE_ADDR;
    out_of_range = ({1'b0, offset} >= SPAN);
    mask_ok      = (cur_mask == 4'b0001) || (cur_mask == 4'b0011) || (cur_mask == 4'b1111);
    misaligned   = ((cur_mask == 4'b0011) && cur_addr[0]) ||
                   ((cur_mask == 4'b1111) && (cur_addr[1:0] != 2'b00));
    txn_err      = cur_conflict || !mask_ok || misaligned || out_of_range;
    word_idx     = offset[IDX_W+1:2];
    lanes        = 4'(cur_mask << cur_addr[1:0]);
    case (cur_mask)
      4'b0001: wdata_rep = {4{cur_wdata[7:0]}};
      4'b0011: wdata_rep = {2{cur_wdata[15:0]}};
      default: wdata_rep = cur_wdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_resp = (state_next == S_RESP);
  // Reset on the commit edge must suppress the access
  assign wr_en      = enter_resp && !rst && !txn_err && !cur_read;
  assign rd_en      = enter_resp && !rst && !txn_err && cur_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= enter_resp && !txn_err;
      err_reg   <= enter_resp && txn_err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_reg     <= addr_i;
      wdata_reg    <= wdata_i;
      mask_reg     <= byte_mask_i;
      unsign_reg   <= un_sign_i;
      is_read_reg  <= mem_re_i;
      conflict_reg <= mem_re_i && mem_we_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg  <= 1'b0;
      rd_off_reg    <= '0;
      rd_mask_reg   <= '0;
      rd_unsign_reg <= 1'b0;
    end else if (rd_en) begin
      rd_valid_reg  <= 1'b1;
      rd_off_reg    <= cur_addr[1:0];
      rd_mask_reg   <= cur_mask;
      rd_unsign_reg <= cur_unsign;
    end
  end

  // One byte-wide RAM per lane keeps the byte enables trivially inferable
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q;
      always_ff @(posedge clk) begin
        if (wr_en && lanes[gi]) lane_mem[word_idx] <= wdata_rep[gi*8 +: 8];
        if (rd_en)              lane_q             <= lane_mem[word_idx];
      end
      assign ram_q[gi*8 +: 8] = lane_q;
    end
  endgenerate

  always_comb begin
    shifted = ram_q >> {rd_off_reg, 3'b000};
    case (rd_mask_reg)
      4'b0001: ext = rd_unsign_reg ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      4'b0011: ext = rd_unsign_reg ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = ram_q;
    endcase
    rdata_o = rd_valid_reg ? ext : 32'h0;
  end

  assign ack_o  = ack_reg;
  assign err_o  = err_reg;
  assign busy_o = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sb_dmem.sv
// Randomized bench for sb_dmem: three instances (0, 1 and 3 wait states)
// checked against a byte-array memory model.
module tb_sb_dmem;

  localparam int DEPTH = 64;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_s [3];
  logic        us_s [3];
  logic        re_s [3];
  logic        we_s [3];
  logic [3:0]  mask_s [3];
  logic [31:0] addr_s [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata [3];
  logic        ack [3];
  logic        err [3];
  logic        busy [3];

  sb_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst_s[0]), .un_sign_i(us_s[0]), .byte_mask_i(mask_s[0]),
    .mem_re_i(re_s[0]), .mem_we_i(we_s[0]), .addr_i(addr_s[0]), .wdata_i(wdata_s[0]),
    .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0]));

  sb_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst_s[1]), .un_sign_i(us_s[1]), .byte_mask_i(mask_s[1]),
    .mem_re_i(re_s[1]), .mem_we_i(we_s[1]), .addr_i(addr_s[1]), .wdata_i(wdata_s[1]),
    .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1]));

  sb_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_4000), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst_s[2]), .un_sign_i(us_s[2]), .byte_mask_i(mask_s[2]),
    .mem_re_i(re_s[2]), .mem_we_i(we_s[2]), .addr_i(addr_s[2]), .wdata_i(wdata_s[2]),
    .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]), .busy_o(busy[2]));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  ref_mem [3][NB];
  logic [31:0] last_rd [3];
  int          last_ack_cyc [3];

  function automatic logic [31:0] base_of(int k);
    return (k == 2) ? 32'h0000_4000 : 32'h0000_0000;
  endfunction

  function automatic int wait_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as bytes, accesses as (offset, size) byte runs
  task automatic model_txn(input int k, input bit re, input bit we, input logic [3:0] m,
                           input bit us, input logic [31:0] a, input logic [31:0] d,
                           output bit e_err, output logic [31:0] e_rd);
    logic [31:0] off;
    logic [31:0] v;
    int sz;
    off = a - base_of(k);
    case (m)
      4'b0001: sz = 1;
      4'b0011: sz = 2;
      4'b1111: sz = 4;
      default: sz = 0;
    endcase
    e_err = (re && we) || (sz == 0) || (off >= NB);
    if (sz != 0 && (a % sz) != 0) e_err = 1'b1;
    if (!e_err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[k][int'(off) + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[k][int'(off) + i];
        if (sz < 4 && !us && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        last_rd[k] = v;
      end
    end
    e_rd = last_rd[k];
  endtask

  task automatic drive(int k, bit re, bit we, logic [3:0] m, bit us, logic [31:0] a, logic [31:0] d);
    re_s[k] = re; we_s[k] = we; mask_s[k] = m; us_s[k] = us; addr_s[k] = a; wdata_s[k] = d;
  endtask

  // Returns at a falling edge with the DUT idle, so the next rising edge can accept
  task automatic wait_idle(int k);
    int n = 0;
    @(negedge clk);
    while (busy[k] === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(busy[k]), 32'd0);
  endtask

  task automatic run_txn(int k, bit re, bit we, logic [3:0] m, bit us, logic [31:0] a,
                         logic [31:0] d, bit hold, bit perturb, bit gap, string tag);
    bit          e_err;
    logic [31:0] e_rd;
    int          n;
    bit          done;
    bit          busy_ok;
    model_txn(k, re, we, m, us, a, d, e_err, e_rd);
    wait_idle(k);
    drive(k, re, we, m, us, a, d);
    @(posedge clk); #1;
    n = 0; done = 0; busy_ok = 1;
    while (!done && n < 40) begin
      n++;
      if (busy[k] !== 1'b1) busy_ok = 0;
      if (perturb && n == 1) begin
        addr_s[k] = a ^ 32'h4; wdata_s[k] = ~d; us_s[k] = ~us;
      end
      if (ack[k] === 1'b1 || err[k] === 1'b1) done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'(wait_of(k) + 1));
    check({tag, "_ack"}, 32'(ack[k]), 32'(!e_err));
    check({tag, "_err"}, 32'(err[k]), 32'(e_err));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_rdata"}, rdata[k], e_rd);
    if (gap) check({tag, "_gap"}, 32'(cyc - last_ack_cyc[k]), 32'd2);
    last_ack_cyc[k] = cyc;
    if (!hold) drive(k, 0, 0, 4'h0, 0, 32'h0, 32'h0);
  endtask

  task automatic init_mem(int k);
    for (int w = 0; w < DEPTH; w++)
      run_txn(k, 0, 1, 4'hF, 0, base_of(k) + 32'(4*w), $urandom, 0, 0, 0, "init");
  endtask

  task automatic rand_phase(int k, int cnt);
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] d;
    int          sz;
    int          r;
    bit          re;
    bit          we;
    bit          us;
    for (int t = 0; t < cnt; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      begin m = 4'b0001; sz = 1; end
      else if (r < 7) begin m = 4'b0011; sz = 2; end
      else if (r < 9) begin m = 4'b1111; sz = 4; end
      else            begin m = 4'($urandom); sz = 1; end
      a = base_of(k) + 32'($urandom_range(0, NB + 15)) - 32'd8;
      if ($urandom_range(0, 7) != 0) a = a & ~(32'(sz) - 32'd1);
      r  = $urandom_range(0, 19);
      re = (r == 0) || (r >= 10);
      we = (r < 10);
      us = 1'($urandom_range(0, 1));
      d  = $urandom;
      run_txn(k, re, we, m, us, a, d, 0, 0, 0, "rnd");
    end
  endtask

  task automatic reset_mid_write();
    int acks = 0;
    wait_idle(1);
    drive(1, 0, 1, 4'hF, 0, 32'h20, 32'h5555_5555);
    @(posedge clk); #1;
    check("rst_busy_pre", 32'(busy[1]), 32'd1);
    @(negedge clk);
    rst_s[1] = 1'b1;
    @(posedge clk); #1;
    check("rst_rdata", rdata[1], 32'h0);
    check("rst_ack", 32'(ack[1]), 32'd0);
    check("rst_err", 32'(err[1]), 32'd0);
    check("rst_busy", 32'(busy[1]), 32'd0);
    last_rd[1] = 32'h0;
    @(negedge clk);
    rst_s[1] = 1'b0;
    drive(1, 0, 0, 4'h0, 0, 32'h0, 32'h0);
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] === 1'b1 || err[1] === 1'b1) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    run_txn(1, 1, 0, 4'hF, 0, 32'h20, 32'h0, 0, 0, 0, "rst_rd_old");
  endtask

  // Read request held high continuously: one ack every other cycle
  task automatic stream_test();
    bit          e_err;
    logic [31:0] e_rd;
    int          acks = 0;
    bit          prev = 0;
    bit          consec = 0;
    bit          rd_ok = 1;
    model_txn(0, 1, 0, 4'hF, 0, 32'h18, 32'h0, e_err, e_rd);
    wait_idle(0);
    drive(0, 1, 0, 4'hF, 0, 32'h18, 32'h0);
    repeat (8) begin
      @(posedge clk); #1;
      if (ack[0] === 1'b1) begin
        acks++;
        if (prev) consec = 1;
        if (rdata[0] !== e_rd) rd_ok = 0;
      end
      prev = (ack[0] === 1'b1);
    end
    @(negedge clk);
    drive(0, 0, 0, 4'h0, 0, 32'h0, 32'h0);
    check("stream_acks", 32'(acks), 32'd4);
    check("stream_consec", 32'(consec), 32'd0);
    check("stream_rdata", 32'(rd_ok), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1;
      drive(k, 0, 0, 4'h0, 0, 32'h0, 32'h0);
      last_rd[k] = 32'h0;
      last_ack_cyc[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_rdata", rdata[k], 32'h0);
      check("reset_ack", 32'(ack[k]), 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
      check("reset_busy", 32'(busy[k]), 32'd0);
    end

    for (int k = 0; k < 3; k++) init_mem(k);

    // Directed sequence, one wait state
    run_txn(1, 0, 1, 4'hF, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, "w_word");
    run_txn(1, 1, 0, 4'hF, 0, 32'h10, 32'h0, 0, 0, 0, "r_word");
    check("r_word_lit", rdata[1], 32'hDEAD_BEEF);
    run_txn(1, 1, 0, 4'h1, 0, 32'h13, 32'h0, 0, 0, 0, "r_sbyte");
    check("r_sbyte_lit", rdata[1], 32'hFFFF_FFDE);
    run_txn(1, 1, 0, 4'h1, 1, 32'h13, 32'h0, 0, 0, 0, "r_ubyte");
    check("r_ubyte_lit", rdata[1], 32'h0000_00DE);
    run_txn(1, 0, 1, 4'h3, 0, 32'h12, 32'h0000_1234, 0, 0, 0, "w_half");
    run_txn(1, 1, 0, 4'hF, 0, 32'h10, 32'h0, 0, 0, 0, "r_word2");
    check("r_word2_lit", rdata[1], 32'h1234_BEEF);
    run_txn(1, 1, 0, 4'h3, 0, 32'h12, 32'h0, 0, 0, 0, "r_shalf");
    check("r_shalf_lit", rdata[1], 32'h0000_1234);

    run_txn(1, 1, 0, 4'hF, 0, 32'h11, 32'h0, 0, 0, 0, "e_word_mis");
    check("e_word_mis_lit", 32'(err[1]), 32'd1);
    run_txn(1, 0, 1, 4'h3, 0, 32'h13, 32'h0000_AAAA, 0, 0, 0, "e_half_mis");
    check("e_half_mis_lit", 32'(err[1]), 32'd1);
    run_txn(1, 0, 1, 4'hF, 0, 32'(NB), 32'h1111_2222, 0, 0, 0, "e_range");
    check("e_range_lit", 32'(err[1]), 32'd1);
    run_txn(1, 1, 1, 4'hF, 0, 32'h10, 32'h0BAD_0BAD, 0, 0, 0, "e_conflict");
    check("e_conflict_lit", 32'(err[1]), 32'd1);
    run_txn(1, 1, 0, 4'hF, 0, 32'h10, 32'h0, 0, 0, 0, "r_after_err");
    check("r_after_err_lit", rdata[1], 32'h1234_BEEF);

    reset_mid_write();

    // Zero wait states: back-to-back write/read pairs with the request held
    for (int i = 0; i < 6; i++) begin
      a = 32'(4 * $urandom_range(0, DEPTH - 1));
      d = $urandom;
      run_txn(0, 0, 1, 4'hF, 0, a, d, 1, 0, (i > 0), "w0_pw");
      run_txn(0, 1, 0, 4'hF, 0, a, 32'h0, 1, 0, 1, "w0_pr");
      check("w0_pr_lit", rdata[0], d);
    end
    @(negedge clk);
    drive(0, 0, 0, 4'h0, 0, 32'h0, 32'h0);
    stream_test();

    // Three wait states: inputs changed while busy must be ignored
    run_txn(2, 1, 0, 4'hF, 0, 32'h0000_4010, 32'h0, 0, 1, 0, "w3_pert_rd");
    run_txn(2, 0, 1, 4'hF, 0, 32'h0000_4020, 32'hCAFE_F00D, 0, 1, 0, "w3_pert_wr");
    run_txn(2, 1, 0, 4'hF, 0, 32'h0000_4020, 32'h0, 0, 0, 0, "w3_rd_back");
    check("w3_rd_back_lit", rdata[2], 32'hCAFE_F00D);

    for (int k = 0; k < 3; k++) rand_phase(k, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
